varredura_display: RTL and testbench
====================================

VARREDURA_DISPLAY -- requirements
Module: varredura_display

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning number of buffered and displayed nibble digits, legal range 2..8.
REQ-002 SHALL have parameter SCAN_DIV, default 4, meaning clock cycles each digit stays active during scanning, legal range 1..65535.
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port ready, input, 1, write strobe; din is captured on a rising edge where ready=1.
REQ-006 SHALL have port din, input, 4, nibble to store (din[3]=a, din[0]=d in legacy bit order).
REQ-007 SHALL have port limpa, input, 1, synchronous clear of buffer and FSM.
REQ-008 SHALL have port fim, output, 1, one-cycle pulse when the last digit is written.
REQ-009 SHALL have port cheio, output, 1, level; high while the buffer is full.
REQ-010 SHALL have port seg, output, 7, active-high segments, seg[6:0]=g,f,e,d,c,b,a.
REQ-011 SHALL have port t, output, DIGITS, active-high one-hot digit enable; t[0] is the leftmost (first written) digit.

Function
REQ-012 SHALL implement an FSM with states CARGA (collecting digits) and CHEIO (buffer full, display only).
REQ-013 In CARGA, ready=1 SHALL write din to buffer[wptr] and increment wptr.
REQ-014 A write with wptr=DIGITS-1 SHALL set fim=1 on the following cycle only, move to CHEIO, and leave wptr at 0.
REQ-015 In CHEIO, ready SHALL be ignored; the buffer and wptr are unchanged; cheio=1.
REQ-016 limpa=1 SHALL, next edge, zero all buffer entries and set wptr=0, state=CARGA, and fim=0, from either state.
REQ-017 If limpa and ready are both 1 on the same edge, limpa SHALL win and din SHALL be discarded.
REQ-018 Scanning SHALL run continuously in both states: divider counts 0..SCAN_DIV-1; on wrap, scan index increments modulo DIGITS.
REQ-019 limpa SHALL NOT disturb the divider or the scan index.
REQ-020 t SHALL be the one-hot decode of the registered scan index; seg SHALL be the decode of buffer[index]; both are combinational from registers, so there is zero latency after the index changes.
REQ-021 A digit written in the current cycle SHALL appear on seg from the next cycle if it is indexed.
REQ-022 Decode SHALL be: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.

Reset
REQ-023 Reset SHALL set state=CARGA, wptr=0, all buffer entries=0, divider=0, index=0, fim=0, and cheio=0.
REQ-024 After reset, t SHALL be 1 at bit 0 only and seg SHALL be 0111111.
REQ-025 Reset SHALL take priority over limpa and ready, including mid-load and in CHEIO.

Configuration
REQ-026 Macro VARREDURA_HEX_EN defined: values 10..15 SHALL decode A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
REQ-027 Macro VARREDURA_HEX_EN undefined: values 10..15 SHALL decode as blank 0000000; all other behaviour is identical.

Verification
REQ-028 Reset then four ready writes din=1,2,3,4 on consecutive cycles (DIGITS=4) -> fim high exactly one cycle after the 4th write, and cheio=1 from then on.
REQ-029 In CHEIO, with SCAN_DIV=4 -> t cycles 0001,0010,0100,1000, each for 4 cycles, with seg 0000110,1011011,1001111,1100110 respectively.
REQ-030 In CHEIO, apply ready with din=9 -> buffer unchanged; seg never shows 1101111; fim stays 0.
REQ-031 After two writes, assert limpa and ready with din=7 together -> wptr=0, all digits show 0111111, and 7 is not stored; the next four writes produce fim.
REQ-032 Write din=12 with VARREDURA_HEX_EN defined -> 0111001 when that digit is indexed; without the macro -> 0000000.
REQ-033 Pulse reset while in CHEIO mid-scan -> next cycle cheio=0, t=0001, and seg=0111111.

Source files
------------

// File: rtl/varredura_display_if.sv
// Bus between the display scanner and its host: write strobe, nibble data,
// clear request, and the status/segment/digit-enable outputs.
interface varredura_display_if #(
    parameter int unsigned DIGITS = 4
) ();
    logic              ready;
    logic [3:0]        din;
    logic              limpa;
    logic              fim;
    logic              cheio;
    logic [6:0]        seg;
    logic [DIGITS-1:0] t;

    modport master (
        output ready, din, limpa,
        input  fim, cheio, seg, t
    );

    modport slave (
        input  ready, din, limpa,
        output fim, cheio, seg, t
    );
endinterface

// File: rtl/varredura_display.sv
// Multiplexed 7-segment display driver with a DIGITS-deep nibble buffer.
// Digits are loaded one per ready strobe (CARGA); once full the buffer is
// frozen (CHEIO) until limpa or reset. Scanning runs continuously.
// Optional feature: define VARREDURA_HEX_EN to decode 10..15 as A,b,C,d,E,F
// (otherwise those values are blank).
module varredura_display #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 4
) (
    input logic                clock,
    input logic                reset,
    varredura_display_if.slave bus
);
    localparam int unsigned IW = $clog2(DIGITS);

    typedef enum logic {CARGA, CHEIO} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   wptr_q, wptr_d;
    logic            fim_q, fim_d;
    logic            wr_en;
    logic [3:0]      digit_q [DIGITS];
    logic [15:0]     div_q;
    logic [IW-1:0]   idx_q;
    logic [3:0]      cur;
    logic [6:0]      seg_dec;
    logic [DIGITS-1:0] t_dec;

    // Next-state logic: limpa overrides any write; CHEIO ignores ready.
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        fim_d   = 1'b0;
        wr_en   = 1'b0;
        if (bus.limpa) begin
            state_d = CARGA;
            wptr_d  = '0;
        end else begin
            case (state_q)
                CARGA: begin
                    if (bus.ready) begin
                        wr_en = 1'b1;
                        if (wptr_q == IW'(DIGITS - 1)) begin
                            wptr_d  = '0;
                            state_d = CHEIO;
                            fim_d   = 1'b1;
                        end else begin
                            wptr_d = wptr_q + 1'b1;
                        end
                    end
                end
                CHEIO: begin
                    state_d = CHEIO;
                end
                default: state_d = CARGA;
            endcase
        end
    end

    // FSM state, write pointer and fim pulse registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= CARGA;
            wptr_q  <= '0;
            fim_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            fim_q   <= fim_d;
        end
    end

    // Digit buffer: cleared by reset or limpa, written only in CARGA.
    always_ff @(posedge clock) begin
        if (reset || bus.limpa) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                digit_q[i] <= 4'h0;
            end
        end else if (wr_en) begin
            digit_q[wptr_q] <= bus.din;
        end
    end

    // Scan divider and digit index; deliberately untouched by limpa.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (div_q == 16'(SCAN_DIV - 1)) begin
            div_q <= '0;
            idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            div_q <= div_q + 16'd1;
        end
    end

    // Combinational outputs straight from registers: one-hot enable and segment decode.
    always_comb begin
        t_dec        = '0;
        t_dec[idx_q] = 1'b1;
        cur          = digit_q[idx_q];
        case (cur)
            4'd0:    seg_dec = 7'b0111111;
            4'd1:    seg_dec = 7'b0000110;
            4'd2:    seg_dec = 7'b1011011;
            4'd3:    seg_dec = 7'b1001111;
            4'd4:    seg_dec = 7'b1100110;
            4'd5:    seg_dec = 7'b1101101;
            4'd6:    seg_dec = 7'b1111101;
            4'd7:    seg_dec = 7'b0000111;
            4'd8:    seg_dec = 7'b1111111;
            4'd9:    seg_dec = 7'b1101111;
`ifdef VARREDURA_HEX_EN
            4'd10:   seg_dec = 7'b1110111;
            4'd11:   seg_dec = 7'b1111100;
            4'd12:   seg_dec = 7'b0111001;
            4'd13:   seg_dec = 7'b1011110;
            4'd14:   seg_dec = 7'b1111001;
            4'd15:   seg_dec = 7'b1110001;
`else
            default: seg_dec = 7'b0000000;
`endif
        endcase
    end

    assign bus.t     = t_dec;
    assign bus.seg   = seg_dec;
    assign bus.fim   = fim_q;
    assign bus.cheio = (state_q == CHEIO);
endmodule

// File: tb/tb_varredura_display.sv
// Directed self-checking bench for varredura_display (DIGITS=4, SCAN_DIV=4).
module tb_varredura_display;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   cyc;
    logic [3:0] mbuf [4];
    logic found;

    logic [6:0] seg_tab [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111,
`ifdef VARREDURA_HEX_EN
        7'b1110111, 7'b1111100, 7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
`else
        7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
`endif
    };

    varredura_display_if #(.DIGITS(4)) bus ();

    varredura_display #(.DIGITS(4), .SCAN_DIV(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Edges since the last reset edge; scan index = (cyc/4)%4.
    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_scan(input string tag);
        int idx;
        idx = (cyc / 4) % 4;
        check({tag, ".t"}, 32'(bus.t), 32'(4'b0001 << idx));
        check({tag, ".seg"}, 32'(bus.seg), 32'(seg_tab[mbuf[idx]]));
    endtask

    initial begin
        bus.ready = 1'b0;
        bus.din   = 4'h0;
        bus.limpa = 1'b0;
        foreach (mbuf[i]) mbuf[i] = 4'h0;

        // Reset state
        @(negedge clock);
        @(negedge clock);
        check("rst.cheio", 32'(bus.cheio), 0);
        check("rst.fim", 32'(bus.fim), 0);
        check("rst.t", 32'(bus.t), 32'h1);
        check("rst.seg", 32'(bus.seg), 32'(7'b0111111));

        // Load 1,2,3,4 on consecutive cycles
        reset     = 1'b0;
        bus.ready = 1'b1;
        bus.din   = 4'd1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            mbuf[k-1] = 4'(k);
            if (k < 4) begin
                check("load.fim_low", 32'(bus.fim), 0);
                check("load.cheio_low", 32'(bus.cheio), 0);
                bus.din = 4'(k + 1);
            end else begin
                check("load.fim_pulse", 32'(bus.fim), 1);
                check("load.cheio", 32'(bus.cheio), 1);
                bus.ready = 1'b0;
            end
            check_scan("load.scan");
        end
        @(negedge clock);
        check("load.fim_one_cycle", 32'(bus.fim), 0);
        check("load.cheio_hold", 32'(bus.cheio), 1);

        // Full scan in CHEIO
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            check_scan("cheio.scan");
            check("cheio.cheio", 32'(bus.cheio), 1);
        end

        // ready with din=9 ignored in CHEIO
        bus.ready = 1'b1;
        bus.din   = 4'd9;
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            check_scan("ign.scan");
            check("ign.fim", 32'(bus.fim), 0);
            check("ign.no9", 32'(bus.seg == 7'b1101111), 0);
        end
        bus.ready = 1'b0;

        // limpa from CHEIO
        bus.limpa = 1'b1;
        @(negedge clock);
        bus.limpa = 1'b0;
        foreach (mbuf[i]) mbuf[i] = 4'h0;
        check("clr.cheio", 32'(bus.cheio), 0);
        check("clr.fim", 32'(bus.fim), 0);
        check_scan("clr.scan");

        // Two writes, then limpa+ready(7) together
        bus.ready = 1'b1;
        bus.din   = 4'd5;
        @(negedge clock);
        mbuf[0]   = 4'd5;
        check_scan("pre.scan0");
        bus.din   = 4'd6;
        @(negedge clock);
        mbuf[1]   = 4'd6;
        check_scan("pre.scan1");
        bus.limpa = 1'b1;
        bus.din   = 4'd7;
        @(negedge clock);
        bus.limpa = 1'b0;
        bus.ready = 1'b0;
        foreach (mbuf[i]) mbuf[i] = 4'h0;
        check("both.cheio", 32'(bus.cheio), 0);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clock);
            check_scan("both.zero");
        end

        // Four writes from wptr=0: 8,9,12,0
        bus.ready = 1'b1;
        bus.din   = 4'd8;
        @(negedge clock);
        mbuf[0] = 4'd8;
        check("re.fim0", 32'(bus.fim), 0);
        bus.din = 4'd9;
        @(negedge clock);
        mbuf[1] = 4'd9;
        check("re.fim1", 32'(bus.fim), 0);
        bus.din = 4'd12;
        @(negedge clock);
        mbuf[2] = 4'd12;
        check("re.fim2", 32'(bus.fim), 0);
        check("re.cheio2", 32'(bus.cheio), 0);
        bus.din = 4'd0;
        @(negedge clock);
        mbuf[3] = 4'd0;
        bus.ready = 1'b0;
        check("re.fim3", 32'(bus.fim), 1);
        check("re.cheio3", 32'(bus.cheio), 1);

        // Scan including the hex/blank digit 12
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            check_scan("hex.scan");
        end

        // Reset mid-scan in CHEIO (index 2, divider 1)
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if ((cyc % 16) == 9) begin
                found = 1'b1;
                break;
            end
        end
        check("rst2.reach_midscan", 32'(found), 1);
        check("rst2.pre_cheio", 32'(bus.cheio), 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        foreach (mbuf[i]) mbuf[i] = 4'h0;
        check("rst2.cheio", 32'(bus.cheio), 0);
        check("rst2.fim", 32'(bus.fim), 0);
        check("rst2.t", 32'(bus.t), 32'h1);
        check("rst2.seg", 32'(bus.seg), 32'(7'b0111111));
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            check_scan("rst2.scan");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
